// File: rtl/sseg_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sseg_pkg
// Purpose : Shared types and constants for the sequential BCD converter.
// Rev     : 1.0
// ============================================================================
package sseg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int BCD_DIGIT_W = 4;
    localparam int ADD3_THRESH = 5;

endpackage : sseg_pkg
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// ============================================================================
// Module  : bcd_digit_adj
// Purpose : Double-dabble digit correction: adds 3 when the digit is >= 5.
// Rev     : 1.0
// ============================================================================
module bcd_digit_adj
    import sseg_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    localparam logic [BCD_DIGIT_W-1:0] c_thresh = BCD_DIGIT_W'(ADD3_THRESH);
    localparam logic [BCD_DIGIT_W-1:0] c_add    = BCD_DIGIT_W'(3);

    always_comb begin
        o_digit = i_digit;
        if (i_digit >= c_thresh) begin
            o_digit = i_digit + c_add;
        end
    end

endmodule : bcd_digit_adj
`default_nettype wire

// File: rtl/bcd_seq_conv.sv
`default_nettype none
// ============================================================================
// Module  : bcd_seq_conv
// Purpose : Iterative binary-to-BCD converter (double dabble, one bit/clock).
// Rev     : 1.0
// ============================================================================
module bcd_seq_conv
    import sseg_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [WIDTH-1:0]                bin_in,
    output logic                            busy,
    output logic                            done,
    output logic [BCD_DIGIT_W*DIGITS-1:0]   bcd_out,
    output logic                            ovf
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_shift;
    logic [BCD_W-1:0]   r_scratch;
    logic               r_ovf_scr;
    logic [CNT_W-1:0]   r_cnt;

    logic [BCD_W-1:0]   w_adj;
    logic [BCD_W-1:0]   w_scratch_nxt;
    logic [WIDTH-1:0]   w_shift_nxt;
    logic               w_ovf_nxt;
    logic               w_accept;
    logic               w_last;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_digit_adj u_adj (
                .i_digit (r_scratch[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .o_digit (w_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    // The bit leaving the top digit is a whole multiple of 10^DIGITS, so
    // dropping it leaves the result modulo 10^DIGITS and flags overflow.
    assign w_scratch_nxt = {w_adj[BCD_W-2:0], r_shift[WIDTH-1]};
    assign w_shift_nxt   = {r_shift[WIDTH-2:0], 1'b0};
    assign w_ovf_nxt     = r_ovf_scr | w_adj[BCD_W-1];

    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last   = (r_state == CONV) && (r_cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = CONV;
                end
            end
            CONV: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = start ? CONV : IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            CONV:    busy = 1'b1;
            DONE:    done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift   <= '0;
            r_scratch <= '0;
            r_ovf_scr <= 1'b0;
            r_cnt     <= '0;
            bcd_out   <= '0;
            ovf       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_shift   <= bin_in;
                r_scratch <= '0;
                r_ovf_scr <= 1'b0;
                r_cnt     <= CNT_W'(WIDTH);
            end else if (r_state == CONV) begin
                r_shift   <= w_shift_nxt;
                r_scratch <= w_scratch_nxt;
                r_ovf_scr <= w_ovf_nxt;
                r_cnt     <= r_cnt - CNT_W'(1);
                // Results are published from the final shift so they land with done.
                if (w_last) begin
                    bcd_out <= w_scratch_nxt;
                    ovf     <= w_ovf_nxt;
                end
            end
        end
    end

endmodule : bcd_seq_conv
`default_nettype wire

// File: tb/tb_bcd_seq_conv.sv
`default_nettype none
// ============================================================================
// Module  : tb_bcd_seq_conv
// Purpose : Directed self-checking bench for bcd_seq_conv (3- and 2-digit).
// Rev     : 1.0
// ============================================================================
module tb_bcd_seq_conv;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  bin_in;
    logic        busy;
    logic        done;
    logic [11:0] bcd_out;
    logic        ovf;

    logic        start2;
    logic [7:0]  bin_in2;
    logic        busy2;
    logic        done2;
    logic [7:0]  bcd_out2;
    logic        ovf2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_seq_conv #(.WIDTH(8), .DIGITS(3)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .ovf     (ovf)
    );

    bcd_seq_conv #(.WIDTH(8), .DIGITS(2)) u_dut2 (
        .clk     (clk),
        .rst     (rst),
        .start   (start2),
        .bin_in  (bin_in2),
        .busy    (busy2),
        .done    (done2),
        .bcd_out (bcd_out2),
        .ovf     (ovf2)
    );

    function automatic logic [11:0] dec3(input int v);
        return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Starts a conversion at the current negedge and waits (bounded) for done.
    task automatic do_conv(input bit sel, input logic [7:0] v,
                           output logic [11:0] res, output logic res_ovf,
                           output int lat, output int busy_cnt);
        int n;
        if (sel) begin
            bin_in2 = v;
            start2  = 1'b1;
        end else begin
            bin_in = v;
            start  = 1'b1;
        end
        n        = 0;
        busy_cnt = 0;
        lat      = -1;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                start  = 1'b0;
                start2 = 1'b0;
            end
            if ((sel ? busy2 : busy) === 1'b1) busy_cnt++;
            if ((sel ? done2 : done) === 1'b1) begin
                lat = n - 1;
                break;
            end
        end
        res     = sel ? {4'h0, bcd_out2} : bcd_out;
        res_ovf = sel ? ovf2 : ovf;
    endtask

    task automatic test_reset();
        rst     = 1'b0;
        start   = 1'b0;
        start2  = 1'b0;
        bin_in  = 8'd0;
        bin_in2 = 8'd0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, ovf} !== 3'b000 || bcd_out !== 12'h000) begin
            errors++;
            $display("FAIL reset3: busy=%b done=%b ovf=%b bcd=%h, expected all zero",
                     busy, done, ovf, bcd_out);
        end
        checks++;
        if ({busy2, done2, ovf2} !== 3'b000 || bcd_out2 !== 8'h00) begin
            errors++;
            $display("FAIL reset2: busy=%b done=%b ovf=%b bcd=%h, expected all zero",
                     busy2, done2, ovf2, bcd_out2);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_latency();
        logic [11:0] res;
        logic        rov;
        int          lat, bc;
        do_conv(1'b0, 8'd255, res, rov, lat, bc);
        checks++;
        if (lat != 8 || bc != 8) begin
            errors++;
            $display("FAIL latency: lat=%0d busy_cycles=%0d, expected 8 8", lat, bc);
        end
        checks++;
        if (res !== 12'h255 || rov !== 1'b0) begin
            errors++;
            $display("FAIL conv255: bcd=%h ovf=%b, expected 255 0", res, rov);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || bcd_out !== 12'h255) begin
            errors++;
            $display("FAIL hold255: done=%b busy=%b bcd=%h, expected 0 0 255",
                     done, busy, bcd_out);
        end
    endtask

    task automatic test_sweep();
        logic [11:0] res;
        logic        rov;
        int          lat, bc;
        for (int v = 0; v < 256; v++) begin
            do_conv(1'b0, 8'(v), res, rov, lat, bc);
            checks++;
            if (res !== dec3(v) || rov !== 1'b0 || lat != 8) begin
                errors++;
                $display("FAIL sweep v=%0d: bcd=%h ovf=%b lat=%0d, expected %h 0 8",
                         v, res, rov, lat, dec3(v));
            end
        end
    endtask

    task automatic test_back_to_back();
        int          n, found, t1, t2;
        logic [11:0] r1, r2;
        bin_in = 8'd0;
        start  = 1'b1;
        n = 0; found = 0; t1 = -1; t2 = -1; r1 = 'x; r2 = 'x;
        while (n < 40 && found < 2) begin
            @(negedge clk);
            n++;
            if (n == 1) bin_in = 8'd99;
            if (done === 1'b1) begin
                if (found == 0) begin
                    t1 = n; r1 = bcd_out;
                end else begin
                    t2 = n; r2 = bcd_out;
                end
                found++;
            end
        end
        start = 1'b0;
        checks++;
        if (t1 != 9 || t2 != 18) begin
            errors++;
            $display("FAIL b2b_timing: done at %0d,%0d, expected 9,18", t1, t2);
        end
        checks++;
        if (r1 !== 12'h000 || r2 !== 12'h099) begin
            errors++;
            $display("FAIL b2b_values: bcd %h,%h, expected 000,099", r1, r2);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stop: busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_start_during_conv();
        int          n, cnt, t;
        logic [11:0] r;
        bin_in = 8'd128;
        start  = 1'b1;
        n = 0; cnt = 0; t = -1; r = 'x;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) begin
                cnt++; t = n; r = bcd_out;
            end
            if (n == 1) start = 1'b0;
            if (n == 3) begin
                start  = 1'b1;
                bin_in = 8'd7;
            end
            if (n == 4) start = 1'b0;
        end
        checks++;
        if (cnt != 1 || t != 9) begin
            errors++;
            $display("FAIL restart_ignored: done_count=%0d at %0d, expected 1 at 9", cnt, t);
        end
        checks++;
        if (r !== 12'h128) begin
            errors++;
            $display("FAIL restart_operand: bcd=%h, expected 128", r);
        end
    endtask

    task automatic test_reset_abort();
        logic [11:0] res;
        logic        rov;
        int          lat, bc, seen;
        bin_in = 8'd200;
        start  = 1'b1;
        repeat (4) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({busy, done, ovf} !== 3'b000 || bcd_out !== 12'h000) begin
            errors++;
            $display("FAIL abort_clear: busy=%b done=%b ovf=%b bcd=%h, expected zeros",
                     busy, done, ovf, bcd_out);
        end
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_nodone: done seen %0d times, expected 0", seen);
        end
        rst = 1'b1;
        do_conv(1'b0, 8'd42, res, rov, lat, bc);
        checks++;
        if (res !== 12'h042 || rov !== 1'b0 || lat != 8) begin
            errors++;
            $display("FAIL after_abort: bcd=%h ovf=%b lat=%0d, expected 042 0 8", res, rov, lat);
        end
    endtask

    task automatic test_overflow_2dig();
        logic [11:0] res;
        logic        rov;
        int          lat, bc;
        do_conv(1'b1, 8'd200, res, rov, lat, bc);
        checks++;
        if (res[7:0] !== 8'h00 || rov !== 1'b1 || lat != 8) begin
            errors++;
            $display("FAIL ovf200: bcd=%h ovf=%b lat=%0d, expected 00 1 8", res[7:0], rov, lat);
        end
        @(negedge clk);
        checks++;
        if (ovf2 !== 1'b1 || bcd_out2 !== 8'h00) begin
            errors++;
            $display("FAIL ovf_hold: ovf=%b bcd=%h, expected 1 00", ovf2, bcd_out2);
        end
        do_conv(1'b1, 8'd57, res, rov, lat, bc);
        checks++;
        if (res[7:0] !== 8'h57 || rov !== 1'b0) begin
            errors++;
            $display("FAIL conv57: bcd=%h ovf=%b, expected 57 0", res[7:0], rov);
        end
        do_conv(1'b1, 8'd99, res, rov, lat, bc);
        checks++;
        if (res[7:0] !== 8'h99 || rov !== 1'b0) begin
            errors++;
            $display("FAIL conv99: bcd=%h ovf=%b, expected 99 0", res[7:0], rov);
        end
        do_conv(1'b1, 8'd100, res, rov, lat, bc);
        checks++;
        if (res[7:0] !== 8'h00 || rov !== 1'b1) begin
            errors++;
            $display("FAIL conv100: bcd=%h ovf=%b, expected 00 1", res[7:0], rov);
        end
        do_conv(1'b1, 8'd255, res, rov, lat, bc);
        checks++;
        if (res[7:0] !== 8'h55 || rov !== 1'b1) begin
            errors++;
            $display("FAIL conv255_2dig: bcd=%h ovf=%b, expected 55 1", res[7:0], rov);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_sweep();
        test_back_to_back();
        test_start_during_conv();
        test_reset_abort();
        test_overflow_2dig();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

endmodule : tb_bcd_seq_conv
`default_nettype wire
